gemv_stream: RTL and testbench

//   Streaming signed-int GEMV y = requant(W*x + b) for the accelerator's dense layers.

---
 rtl/gemv_stream_pkg.sv | 41 ++++
 rtl/gemv_stream_mac_tile.sv | 42 ++++
 rtl/gemv_stream.sv | 233 +++++++++++++++++++++++
 tb/tb_gemv_stream.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemv_stream_pkg.sv
// Shared types and requantisation helpers for the streaming GEMV engine.
package gemv_stream_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_DRAIN = 3'd2,
      S_QUANT = 3'd3,
      S_EMIT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam int DEF_ACC_WIDTH = 32;

   // Requantisation runs on a fixed wide intermediate so that bias add and
   // rounding can never wrap for any legal ACC_WIDTH.
   localparam int WIDE = 64;
   localparam logic signed [WIDE-1:0] WIDE_ONE = 64'sd1;

   // Round half up, then arithmetic shift right.
   function automatic logic signed [WIDE-1:0] round_shift(
      input logic signed [WIDE-1:0] t,
      input logic [4:0]             sh
   );
      logic signed [WIDE-1:0] r;
      r = t;
      if (sh != 5'd0) begin
         r = t + (WIDE_ONE <<< (sh - 5'd1));
      end
      return r >>> sh;
   endfunction

   function automatic logic signed [WIDE-1:0] sat_max(input int dw);
      return (WIDE_ONE <<< (dw - 1)) - WIDE_ONE;
   endfunction

   function automatic logic signed [WIDE-1:0] sat_min(input int dw);
      return -(WIDE_ONE <<< (dw - 1));
   endfunction

endpackage

// File: rtl/gemv_stream_mac_tile.sv
// One weight tile: TILE_SIZE signed lane products summed by an adder tree,
// registered into psum with a matching valid flag.
module gemv_stream_mac_tile #(
   parameter int DATA_WIDTH = 8,
   parameter int TILE_SIZE  = 8,
   parameter int SUM_WIDTH  = 2*DATA_WIDTH + $clog2(TILE_SIZE)
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_vld,
   input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] w_lane,
   input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] x_lane,
   output logic signed [SUM_WIDTH-1:0]          psum,
   output logic                                 psum_vld
);

   logic signed [SUM_WIDTH-1:0] sum_c;

   // Lane multiply and reduction; masked lanes arrive as zero.
   always_comb begin
      logic signed [2*DATA_WIDTH-1:0] prod;
      sum_c = '0;
      for (int i = 0; i < TILE_SIZE; i++) begin
         prod  = $signed(w_lane[i]) * $signed(x_lane[i]);
         sum_c = sum_c + SUM_WIDTH'(prod);
      end
   end

   // Pipeline register between the multiplier tree and the accumulator.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         psum     <= '0;
         psum_vld <= 1'b0;
      end else begin
         psum_vld <= in_vld;
         if (in_vld) begin
            psum <= sum_c;
         end
      end
   end

endmodule

// File: rtl/gemv_stream.sv
// Streaming GEMV y = requant(W*x + b): tiled weight stream in, one
// requantised row per output beat.
//
// state | meaning
// IDLE  | waiting for start; config latched on accept
// FETCH | accepting weight tiles for the current row
// DRAIN | last tile's psum lands in acc
// QUANT | bias add, round, shift, saturate, relu into y_data
// EMIT  | y_valid held until consumer takes the row
// DONE  | one-cycle done pulse, busy drops
module gemv_stream
   import gemv_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int TILE_SIZE  = 8,
   parameter int MAX_ROWS   = 128,
   parameter int MAX_COLS   = 128,
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [$clog2(MAX_ROWS):0]            cfg_rows,
   input  logic [$clog2(MAX_COLS):0]            cfg_cols,
   input  logic [4:0]                           cfg_shift,
   input  logic                                 cfg_relu,
   input  logic [MAX_COLS-1:0][DATA_WIDTH-1:0]  x,
   input  logic [MAX_ROWS-1:0][DATA_WIDTH-1:0]  bias,
   input  logic                                 w_valid,
   output logic                                 w_ready,
   input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] w_data,
   output logic                                 y_valid,
   input  logic                                 y_ready,
   output logic [DATA_WIDTH-1:0]                y_data,
   output logic [$clog2(MAX_ROWS)-1:0]          y_row,
   output logic                                 y_last,
   output logic                                 busy,
   output logic                                 done
);

   localparam int RW  = $clog2(MAX_ROWS) + 1;
   localparam int CW  = $clog2(MAX_COLS) + 1;
   localparam int YW  = $clog2(MAX_ROWS);
   localparam int XIW = $clog2(MAX_COLS);
   localparam int SW  = 2*DATA_WIDTH + $clog2(TILE_SIZE);

   state_t state, state_nxt;

   logic [RW-1:0]                rows_q, row_q, rows_clamp;
   logic [CW-1:0]                cols_q, cols_clamp, ntiles_q, ntiles_c, tile_q;
   logic [CW:0]                  cols_rnd;
   logic [4:0]                   shift_q;
   logic                         relu_q;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic                         w_hs, y_hs, last_tile, last_row;

   logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] w_lane, x_lane;
   logic signed [SW-1:0]         psum;
   logic                         psum_vld;

   logic signed [WIDE-1:0]       t_wide, r_wide;
   logic [DATA_WIDTH-1:0]        q_val;

   assign w_ready = (state == S_FETCH);
   assign y_valid = (state == S_EMIT);
   assign done    = (state == S_DONE);

   assign w_hs      = w_ready && w_valid;
   assign y_hs      = y_valid && y_ready;
   assign last_tile = (tile_q == ntiles_q - CW'(1));
   assign last_row  = (row_q == rows_q - RW'(1));

   // Out-of-range requests are clamped; tile count is ceil(cols/TILE_SIZE).
   always_comb begin
      rows_clamp = (cfg_rows > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : cfg_rows;
      cols_clamp = (cfg_cols > CW'(MAX_COLS)) ? CW'(MAX_COLS) : cfg_cols;
      cols_rnd   = {1'b0, cols_clamp} + (CW+1)'(TILE_SIZE - 1);
      ntiles_c   = CW'(cols_rnd / (CW+1)'(TILE_SIZE));
   end

   // Lanes past the last column are zeroed so a partial final tile adds nothing.
   always_comb begin
      for (int i = 0; i < TILE_SIZE; i++) begin
         int col;
         col       = int'(tile_q) * TILE_SIZE + i;
         w_lane[i] = '0;
         x_lane[i] = '0;
         if (col < int'(cols_q)) begin
            w_lane[i] = w_data[i];
            x_lane[i] = x[col[XIW-1:0]];
         end
      end
   end

   gemv_stream_mac_tile #(
      .DATA_WIDTH (DATA_WIDTH),
      .TILE_SIZE  (TILE_SIZE),
      .SUM_WIDTH  (SW)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (w_hs),
      .w_lane   (w_lane),
      .x_lane   (x_lane),
      .psum     (psum),
      .psum_vld (psum_vld)
   );

   // Requantise the finished row: bias, round-half-up shift, saturate, relu.
   always_comb begin
      t_wide = WIDE'(acc) + WIDE'($signed(bias[row_q[YW-1:0]]));
      r_wide = round_shift(t_wide, shift_q);
      if (r_wide > sat_max(DATA_WIDTH)) begin
         q_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (r_wide < sat_min(DATA_WIDTH)) begin
         q_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         q_val = r_wide[DATA_WIDTH-1:0];
      end
      if (relu_q && q_val[DATA_WIDTH-1]) begin
         q_val = '0;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a row with no columns goes straight to QUANT.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (rows_clamp == '0) begin
                  state_nxt = S_DONE;
               end else if (cols_clamp == '0) begin
                  state_nxt = S_QUANT;
               end else begin
                  state_nxt = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            if (w_hs && last_tile) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: state_nxt = S_QUANT;
         S_QUANT: state_nxt = S_EMIT;
         S_EMIT: begin
            if (y_ready) begin
               if (last_row) begin
                  state_nxt = S_DONE;
               end else if (cols_q == '0) begin
                  state_nxt = S_QUANT;
               end else begin
                  state_nxt = S_FETCH;
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Config latch, counters, accumulator and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rows_q   <= '0;
         cols_q   <= '0;
         ntiles_q <= '0;
         shift_q  <= '0;
         relu_q   <= 1'b0;
         row_q    <= '0;
         tile_q   <= '0;
         acc      <= '0;
         y_data   <= '0;
         y_row    <= '0;
         y_last   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         if (state == S_IDLE && start) begin
            acc <= '0;
         end else if (y_hs) begin
            acc <= '0;
         end else if (psum_vld) begin
            acc <= acc + ACC_WIDTH'(psum);
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  rows_q   <= rows_clamp;
                  cols_q   <= cols_clamp;
                  ntiles_q <= ntiles_c;
                  shift_q  <= cfg_shift;
                  relu_q   <= cfg_relu;
                  row_q    <= '0;
                  tile_q   <= '0;
                  busy     <= 1'b1;
               end
            end
            S_FETCH: begin
               if (w_hs) begin
                  tile_q <= last_tile ? '0 : tile_q + CW'(1);
               end
            end
            S_QUANT: begin
               y_data <= q_val;
               y_row  <= row_q[YW-1:0];
               y_last <= last_row;
            end
            S_EMIT: begin
               if (y_ready) begin
                  row_q  <= row_q + RW'(1);
                  tile_q <= '0;
               end
            end
            S_DONE: begin
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gemv_stream.sv
// Directed bench for gemv_stream with hand-computed expected results.
module tb_gemv_stream;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [7:0]          cfg_rows, cfg_cols;
   logic [4:0]          cfg_shift;
   logic                cfg_relu;
   logic [127:0][7:0]   x, bias;
   logic                w_valid, w_ready;
   logic [7:0][7:0]     w_data;
   logic                y_valid, y_ready, y_last, busy, done;
   logic [7:0]          y_data;
   logic [6:0]          y_row;

   int n_assert = 0;
   int n_fail   = 0;

   logic signed [7:0] wm [0:7][0:15];
   logic signed [7:0] got_y [0:7];
   logic              got_last [0:7];
   int                beats, cyc, extra, hold_err;
   logic              busy_after;

   always #5 clk = ~clk;

   gemv_stream dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
      .x(x), .bias(bias),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_row(y_row), .y_last(y_last),
      .busy(busy), .done(done)
   );

   task automatic clear_data();
      x    = '0;
      bias = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 16; c++)
            wm[r][c] = '0;
   endtask

   task automatic run_job(input int rows, input int cols, input int sh, input bit relu,
                          input bit stall_w, input bit stall_y);
      int          w_row, w_tile, ntiles;
      bit          pend, seen_done;
      logic [7:0]  pd;
      logic [6:0]  pr;
      ntiles = (cols + 7) / 8;
      beats = 0; cyc = 0; extra = 0; hold_err = 0;
      w_row = 0; w_tile = 0; pend = 0; seen_done = 0; pd = '0; pr = '0;
      for (int r = 0; r < 8; r++) begin
         got_y[r]    = 'x;
         got_last[r] = 1'bx;
      end
      @(negedge clk);
      cfg_rows = 8'(rows); cfg_cols = 8'(cols); cfg_shift = 5'(sh); cfg_relu = relu;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!seen_done && cyc < 500) begin
         w_valid = (w_row < rows) && (ntiles > 0) && (!stall_w || $urandom_range(0, 1) == 1);
         w_data  = '0;
         for (int i = 0; i < 8; i++) begin
            int col;
            col = w_tile * 8 + i;
            if (w_valid && col < 16 && w_row < 8) w_data[i] = wm[w_row][col];
         end
         y_ready = !stall_y || ($urandom_range(0, 1) == 1);
         #1;
         cyc++;
         if (pend && (y_valid !== 1'b1 || y_data !== pd || y_row !== pr)) hold_err++;
         pend = y_valid && !y_ready;
         pd   = y_data;
         pr   = y_row;
         if (w_valid && w_ready) begin
            w_tile++;
            if (w_tile == ntiles) begin
               w_tile = 0;
               w_row++;
            end
         end
         if (y_valid && y_ready) begin
            beats++;
            if (y_row < 7'd8) begin
               got_y[y_row]    = y_data;
               got_last[y_row] = y_last;
            end
         end
         if (done) seen_done = 1;
         else @(negedge clk);
      end
      w_valid = 1'b0;
      y_ready = 1'b0;
      if (!seen_done) begin
         n_assert++; n_fail++;
         $display("FAIL job_timeout: done not seen after %0d cycles, want done", cyc);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         if (k == 0) busy_after = busy;
         if (done || y_valid) extra++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; cfg_rows = '0; cfg_cols = '0; cfg_shift = '0; cfg_relu = 1'b0;
      w_valid = 1'b0; w_data = '0; y_ready = 1'b0;
      clear_data();
      @(negedge clk); @(negedge clk); #1;
      n_assert++;
      if ({w_ready, y_valid, y_last, busy, done} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {w_ready, y_valid, y_last, busy, done});
      end
      n_assert++;
      if (y_data !== 8'd0) begin n_fail++; $display("FAIL reset_y_data: got %0d want 0", y_data); end
      n_assert++;
      if (y_row !== 7'd0) begin n_fail++; $display("FAIL reset_y_row: got %0d want 0", y_row); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic load_basic();
      clear_data();
      for (int c = 0; c < 8; c++) begin
         x[c]     = 8'(c + 1);
         wm[0][c] = 8'sd1;
         wm[1][c] = -8'sd1;
      end
   endtask

   task automatic test_basic();
      load_basic();
      run_job(2, 8, 0, 0, 0, 0);
      n_assert++;
      if (got_y[0] !== 8'sd36) begin n_fail++; $display("FAIL basic_row0: got %0d want 36", got_y[0]); end
      n_assert++;
      if (got_y[1] !== -8'sd36) begin n_fail++; $display("FAIL basic_row1: got %0d want -36", got_y[1]); end
      n_assert++;
      if ({got_last[0], got_last[1]} !== 2'b01) begin
         n_fail++; $display("FAIL basic_last: got %b want 01", {got_last[0], got_last[1]});
      end
      n_assert++;
      if (beats != 2) begin n_fail++; $display("FAIL basic_beats: got %0d want 2", beats); end
      n_assert++;
      if (cyc != 9) begin n_fail++; $display("FAIL basic_latency: got %0d want 9", cyc); end
      n_assert++;
      if (busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", busy_after); end
      n_assert++;
      if (extra != 0) begin n_fail++; $display("FAIL basic_extra: got %0d want 0", extra); end
   endtask

   task automatic test_saturate();
      clear_data();
      for (int c = 0; c < 8; c++) begin
         x[c]     = 8'sd127;
         wm[0][c] = 8'sd127;
      end
      run_job(1, 8, 0, 0, 0, 0);
      n_assert++;
      if (got_y[0] !== 8'sd127) begin n_fail++; $display("FAIL sat_pos: got %0d want 127", got_y[0]); end
      n_assert++;
      if (got_last[0] !== 1'b1) begin n_fail++; $display("FAIL sat_last: got %b want 1", got_last[0]); end
      for (int c = 0; c < 8; c++) wm[0][c] = -8'sd127;
      run_job(1, 8, 0, 0, 0, 0);
      n_assert++;
      if (got_y[0] !== -8'sd128) begin n_fail++; $display("FAIL sat_neg: got %0d want -128", got_y[0]); end
      run_job(1, 8, 0, 1, 0, 0);
      n_assert++;
      if (got_y[0] !== 8'sd0) begin n_fail++; $display("FAIL relu: got %0d want 0", got_y[0]); end
   endtask

   task automatic test_partial_tile();
      clear_data();
      for (int c = 0; c < 16; c++) begin
         x[c]     = 8'sd1;
         wm[0][c] = 8'sd1;
      end
      run_job(1, 10, 0, 0, 0, 0);
      n_assert++;
      if (got_y[0] !== 8'sd10) begin n_fail++; $display("FAIL partial_y: got %0d want 10", got_y[0]); end
      n_assert++;
      if (cyc != 6) begin n_fail++; $display("FAIL partial_latency: got %0d want 6", cyc); end
   endtask

   task automatic test_round();
      clear_data();
      bias[0] = 8'sd6;
      bias[1] = -8'sd6;
      run_job(2, 0, 2, 0, 0, 0);
      n_assert++;
      if (got_y[0] !== 8'sd2) begin n_fail++; $display("FAIL round_pos: got %0d want 2", got_y[0]); end
      n_assert++;
      if (got_y[1] !== -8'sd1) begin n_fail++; $display("FAIL round_neg: got %0d want -1", got_y[1]); end
      n_assert++;
      if (cyc != 5) begin n_fail++; $display("FAIL bias_only_latency: got %0d want 5", cyc); end
      load_basic();
      bias[0] = -8'sd6;
      run_job(1, 8, 3, 0, 0, 0);
      n_assert++;
      if (got_y[0] !== 8'sd4) begin n_fail++; $display("FAIL round_acc: got %0d want 4", got_y[0]); end
   endtask

   task automatic load_stall();
      clear_data();
      for (int c = 0; c < 16; c++) x[c] = 8'(c + 1);
      for (int r = 0; r < 4; r++) begin
         bias[r] = 8'(r * 10);
         for (int c = 0; c < 16; c++) wm[r][c] = 8'(r - 1);
      end
   endtask

   task automatic test_back_to_back();
      logic signed [7:0] exp_y [0:3];
      exp_y[0] = -8'sd68; exp_y[1] = 8'sd5; exp_y[2] = 8'sd78; exp_y[3] = 8'sd127;
      load_stall();
      run_job(4, 16, 1, 0, 0, 0);
      for (int r = 0; r < 4; r++) begin
         n_assert++;
         if (got_y[r] !== exp_y[r]) begin
            n_fail++; $display("FAIL b2b_row%0d: got %0d want %0d", r, got_y[r], exp_y[r]);
         end
      end
      n_assert++;
      if (cyc != 21) begin n_fail++; $display("FAIL b2b_latency: got %0d want 21", cyc); end
   endtask

   task automatic test_stall();
      logic signed [7:0] exp_y [0:3];
      exp_y[0] = -8'sd68; exp_y[1] = 8'sd5; exp_y[2] = 8'sd78; exp_y[3] = 8'sd127;
      load_stall();
      run_job(4, 16, 1, 0, 1, 1);
      for (int r = 0; r < 4; r++) begin
         n_assert++;
         if (got_y[r] !== exp_y[r]) begin
            n_fail++; $display("FAIL stall_row%0d: got %0d want %0d", r, got_y[r], exp_y[r]);
         end
      end
      n_assert++;
      if (hold_err != 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes want 0", hold_err); end
      n_assert++;
      if (beats != 4) begin n_fail++; $display("FAIL stall_beats: got %0d want 4", beats); end
      n_assert++;
      if ({got_last[0], got_last[3]} !== 2'b01) begin
         n_fail++; $display("FAIL stall_last: got %b want 01", {got_last[0], got_last[3]});
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      load_stall();
      @(negedge clk);
      cfg_rows = 8'd2; cfg_cols = 8'd16; cfg_shift = 5'd0; cfg_relu = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      w_valid = 1'b1;
      w_data  = {8{8'sd1}};
      @(negedge clk);
      w_valid = 1'b0;
      #1;
      n_assert++;
      if ({w_ready, busy} !== 2'b11) begin
         n_fail++; $display("FAIL midrst_pre: got %b want 11", {w_ready, busy});
      end
      rst = 1'b0;
      #1;
      n_assert++;
      if ({w_ready, busy, y_valid, done, y_data} !== 12'd0) begin
         n_fail++; $display("FAIL midrst_outputs: got %b want 0", {w_ready, busy, y_valid, done, y_data});
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      w_valid = 1'b1;
      y_ready = 1'b1;
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1;
         if (done || y_valid || w_ready || busy) bad++;
      end
      w_valid = 1'b0;
      y_ready = 1'b0;
      n_assert++;
      if (bad != 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles want 0", bad); end
      load_basic();
      run_job(2, 8, 0, 0, 0, 0);
      n_assert++;
      if (got_y[0] !== 8'sd36 || got_y[1] !== -8'sd36) begin
         n_fail++; $display("FAIL midrst_rerun: got %0d,%0d want 36,-36", got_y[0], got_y[1]);
      end
   endtask

   task automatic test_rows_zero();
      load_basic();
      run_job(0, 8, 0, 0, 0, 0);
      n_assert++;
      if (beats != 0) begin n_fail++; $display("FAIL rows0_beats: got %0d want 0", beats); end
      n_assert++;
      if (cyc != 1) begin n_fail++; $display("FAIL rows0_latency: got %0d want 1", cyc); end
      n_assert++;
      if (extra != 0) begin n_fail++; $display("FAIL rows0_extra: got %0d want 0", extra); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_partial_tile();
      test_round();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_rows_zero();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
